// File: rtl/execute_stage_pkg.sv
// Shared types and constants for the RV32I execute stage: ALU opcodes,
// forward selects, result-source codes and the EX/MEM payload.
package execute_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned ALU_CW = 3;
    localparam int unsigned FWD_W  = 2;
    localparam int unsigned RSRC_W = 2;

    typedef enum logic [ALU_CW-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [FWD_W-1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [RSRC_W-1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef struct packed {
        logic              reg_write;
        logic [RSRC_W-1:0] result_src;
        logic              mem_write;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   write_data;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   pc_plus4;
    } exmem_t;

    // Operand forwarding; code 11 is unused by the hazard unit and falls back to the register value.
    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [FWD_W-1:0] sel,
        input logic [XLEN-1:0]  reg_val,
        input logic [XLEN-1:0]  wb_val,
        input logic [XLEN-1:0]  mem_val
    );
        logic [XLEN-1:0] res;
        case (sel)
            FWD_WB:  res = wb_val;
            FWD_MEM: res = mem_val;
            default: res = reg_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage, grouped
// as one bundle. The slave modport is the stage itself.
interface execute_stage_if;
    import execute_stage_pkg::*;

    logic              enable;
    logic              flush;
    logic              RegWriteE;
    logic              MemWriteE;
    logic              JumpE;
    logic              BranchE;
    logic              ALUSrcE;
    logic [RSRC_W-1:0] ResultSrcE;
    logic [ALU_CW-1:0] ALUControlE;
    logic [XLEN-1:0]   RD1E;
    logic [XLEN-1:0]   RD2E;
    logic [XLEN-1:0]   PCE;
    logic [XLEN-1:0]   ImmExtE;
    logic [XLEN-1:0]   PCPlus4E;
    logic [REG_AW-1:0] RdE;
    logic [FWD_W-1:0]  ForwardAE;
    logic [FWD_W-1:0]  ForwardBE;
    logic [XLEN-1:0]   ResultW;

    logic              PCSrcE;
    logic [XLEN-1:0]   PCTargetE;
    logic              RegWriteM;
    logic              MemWriteM;
    logic [RSRC_W-1:0] ResultSrcM;
    logic [XLEN-1:0]   ALUResultM;
    logic [XLEN-1:0]   WriteDataM;
    logic [XLEN-1:0]   PCPlus4M;
    logic [REG_AW-1:0] RdM;

    modport slave (
        input  enable, flush,
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
        input  ResultSrcE, ALUControlE,
        input  RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE,
        input  ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE,
        output RegWriteM, MemWriteM, ResultSrcM,
        output ALUResultM, WriteDataM, PCPlus4M, RdM
    );

    modport master (
        output enable, flush,
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
        output ResultSrcE, ALUControlE,
        output RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE,
        output ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE,
        input  RegWriteM, MemWriteM, ResultSrcM,
        input  ALUResultM, WriteDataM, PCPlus4M, RdM
    );

endinterface

// File: rtl/alu.sv
// Combinational RV32I ALU subset: add, sub, and, or, signed slt.
// Unsupported opcodes produce zero; arithmetic wraps without flags.
module alu
    import execute_stage_pkg::*;
(
    input  logic [XLEN-1:0]   src_a_i,
    input  logic [XLEN-1:0]   src_b_i,
    input  logic [ALU_CW-1:0] alu_control_i,
    output logic [XLEN-1:0]   result_c_o,
    output logic              zero_c_o
);

    always_comb begin
        result_c_o = '0;
        case (alu_control_i)
            ALU_ADD: result_c_o = src_a_i + src_b_i;
            ALU_SUB: result_c_o = src_a_i - src_b_i;
            ALU_AND: result_c_o = src_a_i & src_b_i;
            ALU_OR:  result_c_o = src_a_i | src_b_i;
            ALU_SLT: result_c_o = XLEN'($signed(src_a_i) < $signed(src_b_i));
            default: result_c_o = '0;
        endcase
    end

    assign zero_c_o = (result_c_o == '0);

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution
// (combinational to fetch) and the EX/MEM pipeline register.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    execute_stage_if.slave   ex_if
);

    exmem_t          exmem_q;
    exmem_t          exmem_d;
    logic [XLEN-1:0] src_a_c;
    logic [XLEN-1:0] write_data_c;
    logic [XLEN-1:0] src_b_c;
    logic [XLEN-1:0] alu_result_c;
    logic            zero_c;

    // MEM-stage forwarding uses the currently held EX/MEM result, so stalls keep it stable.
    assign src_a_c      = fwd_mux(ex_if.ForwardAE, ex_if.RD1E, ex_if.ResultW, exmem_q.alu_result);
    assign write_data_c = fwd_mux(ex_if.ForwardBE, ex_if.RD2E, ex_if.ResultW, exmem_q.alu_result);
    assign src_b_c      = ex_if.ALUSrcE ? ex_if.ImmExtE : write_data_c;

    alu u_alu (
        .src_a_i       (src_a_c),
        .src_b_i       (src_b_c),
        .alu_control_i (ex_if.ALUControlE),
        .result_c_o    (alu_result_c),
        .zero_c_o      (zero_c)
    );

    // Redirect is left ungated; fetch and the hazard unit qualify it.
    assign ex_if.PCSrcE    = (ex_if.BranchE & zero_c) | ex_if.JumpE;
    assign ex_if.PCTargetE = ex_if.PCE + ex_if.ImmExtE;

    always_comb begin
        exmem_d = exmem_q;
        if (ex_if.flush) begin
            exmem_d = '0;
        end else if (ex_if.enable) begin
            exmem_d.reg_write  = ex_if.RegWriteE;
            exmem_d.result_src = ex_if.ResultSrcE;
            exmem_d.mem_write  = ex_if.MemWriteE;
            exmem_d.alu_result = alu_result_c;
            exmem_d.write_data = write_data_c;
            exmem_d.rd         = ex_if.RdE;
            exmem_d.pc_plus4   = ex_if.PCPlus4E;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign ex_if.RegWriteM  = exmem_q.reg_write;
    assign ex_if.ResultSrcM = exmem_q.result_src;
    assign ex_if.MemWriteM  = exmem_q.mem_write;
    assign ex_if.ALUResultM = exmem_q.alu_result;
    assign ex_if.WriteDataM = exmem_q.write_data;
    assign ex_if.RdM        = exmem_q.rd;
    assign ex_if.PCPlus4M   = exmem_q.pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU ops, forwarding,
// branch resolution, stall/flush priority and mid-stream reset.
module tb_execute_stage;

    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    execute_stage_if ex_if ();

    execute_stage dut (
        .clock (clock),
        .reset (reset),
        .ex_if (ex_if)
    );

    always #5 clock = ~clock;

    // {RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RdM, PCPlus4M}
    function automatic logic [104:0] mvec();
        return {ex_if.RegWriteM, ex_if.MemWriteM, ex_if.ResultSrcM, ex_if.ALUResultM,
                ex_if.WriteDataM, ex_if.RdM, ex_if.PCPlus4M};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        ex_if.enable      = 1'b1;
        ex_if.flush       = 1'b0;
        ex_if.RegWriteE   = 1'b0;
        ex_if.MemWriteE   = 1'b0;
        ex_if.JumpE       = 1'b0;
        ex_if.BranchE     = 1'b0;
        ex_if.ALUSrcE     = 1'b0;
        ex_if.ResultSrcE  = 2'b00;
        ex_if.ALUControlE = 3'b000;
        ex_if.RD1E        = 32'h0;
        ex_if.RD2E        = 32'h0;
        ex_if.PCE         = 32'h0;
        ex_if.ImmExtE     = 32'h0;
        ex_if.PCPlus4E    = 32'h0;
        ex_if.RdE         = 5'd0;
        ex_if.ForwardAE   = 2'b00;
        ex_if.ForwardBE   = 2'b00;
        ex_if.ResultW     = 32'h0;
    endtask

    initial begin
        logic [104:0] held;

        // Reset: all registered outputs clear
        clear_inputs();
        ex_if.RD1E      = 32'h11;
        ex_if.RegWriteE = 1'b1;
        reset = 1'b1;
        step();
        step();
        check("reset_state", 128'(mvec()), 128'(0));
        reset = 1'b0;
        clear_inputs();

        // add 5 + 7 -> rd 3
        ex_if.RD1E       = 32'd5;
        ex_if.RD2E       = 32'd7;
        ex_if.RdE        = 5'd3;
        ex_if.RegWriteE  = 1'b1;
        ex_if.ResultSrcE = 2'b10;
        ex_if.PCPlus4E   = 32'h104;
        #1;
        check("add_no_redirect", 128'(ex_if.PCSrcE), 128'(0));
        step();
        check("add_regs", 128'(mvec()),
              128'({1'b1, 1'b0, 2'b10, 32'd12, 32'd7, 5'd3, 32'h104}));

        // MEM forward on A: 12 + imm 1
        clear_inputs();
        ex_if.ForwardAE = 2'b10;
        ex_if.ALUSrcE   = 1'b1;
        ex_if.ImmExtE   = 32'd1;
        ex_if.RD2E      = 32'd9;
        step();
        check("fwd_mem_a", 128'(ex_if.ALUResultM), 128'(32'd13));
        check("fwd_mem_a_wd", 128'(ex_if.WriteDataM), 128'(32'd9));

        // WB forward on B feeds store data
        clear_inputs();
        ex_if.ForwardBE = 2'b01;
        ex_if.ResultW   = 32'h55;
        ex_if.MemWriteE = 1'b1;
        ex_if.ALUSrcE   = 1'b1;
        ex_if.ImmExtE   = 32'd1;
        ex_if.RD2E      = 32'hDEAD;
        step();
        check("fwd_wb_b_wd", 128'(ex_if.WriteDataM), 128'(32'h55));
        check("fwd_wb_b_mw", 128'(ex_if.MemWriteM), 128'(1));
        check("fwd_wb_b_alu", 128'(ex_if.ALUResultM), 128'(32'd1));

        // Select 11 falls back to the register operands; WB forward B into ALU
        clear_inputs();
        ex_if.ForwardAE = 2'b11;
        ex_if.ForwardBE = 2'b11;
        ex_if.RD1E      = 32'd3;
        ex_if.RD2E      = 32'd4;
        ex_if.ResultW   = 32'h100;
        step();
        check("fwd_11", 128'(ex_if.ALUResultM), 128'(32'd7));
        ex_if.ForwardBE = 2'b01;
        step();
        check("fwd_wb_b_alu_src", 128'(ex_if.ALUResultM), 128'(32'h103));

        // beq taken / not taken, jump, target wrap
        clear_inputs();
        ex_if.RD1E        = 32'd9;
        ex_if.RD2E        = 32'd9;
        ex_if.ALUControlE = 3'b001;
        ex_if.BranchE     = 1'b1;
        ex_if.PCE         = 32'h100;
        ex_if.ImmExtE     = 32'h20;
        #1;
        check("beq_taken", 128'(ex_if.PCSrcE), 128'(1));
        check("beq_target", 128'(ex_if.PCTargetE), 128'(32'h120));
        ex_if.RD2E = 32'd8;
        #1;
        check("beq_not_taken", 128'(ex_if.PCSrcE), 128'(0));
        ex_if.JumpE = 1'b1;
        #1;
        check("jump_taken", 128'(ex_if.PCSrcE), 128'(1));
        ex_if.JumpE   = 1'b0;
        ex_if.PCE     = 32'hFFFF_FFF0;
        ex_if.ImmExtE = 32'h20;
        #1;
        check("target_wrap", 128'(ex_if.PCTargetE), 128'(32'h10));

        // ALU operation table
        clear_inputs();
        ex_if.RD1E = 32'hFFFF_FFFF; ex_if.RD2E = 32'd1; ex_if.ALUControlE = 3'b101;
        step();
        check("slt_neg_lt_pos", 128'(ex_if.ALUResultM), 128'(32'd1));
        ex_if.RD1E = 32'd1; ex_if.RD2E = 32'hFFFF_FFFF;
        step();
        check("slt_pos_lt_neg", 128'(ex_if.ALUResultM), 128'(32'd0));
        ex_if.RD1E = 32'h7FFF_FFFF; ex_if.RD2E = 32'd1; ex_if.ALUControlE = 3'b000;
        step();
        check("add_wrap", 128'(ex_if.ALUResultM), 128'(32'h8000_0000));
        ex_if.RD1E = 32'd5; ex_if.RD2E = 32'd7; ex_if.ALUControlE = 3'b001;
        step();
        check("sub_neg", 128'(ex_if.ALUResultM), 128'(32'hFFFF_FFFE));
        ex_if.RD1E = 32'hF0F0; ex_if.RD2E = 32'hFF00; ex_if.ALUControlE = 3'b010;
        step();
        check("and", 128'(ex_if.ALUResultM), 128'(32'hF000));
        ex_if.ALUControlE = 3'b011;
        step();
        check("or", 128'(ex_if.ALUResultM), 128'(32'hFFF0));
        ex_if.ALUControlE = 3'b111;
        step();
        check("illegal_op", 128'(ex_if.ALUResultM), 128'(32'd0));

        // Stall holds every field for three cycles of changing inputs
        clear_inputs();
        ex_if.RD1E = 32'd5; ex_if.RD2E = 32'd7; ex_if.RdE = 5'd3;
        ex_if.RegWriteE = 1'b1; ex_if.PCPlus4E = 32'h104;
        step();
        held = {1'b1, 1'b0, 2'b00, 32'd12, 32'd7, 5'd3, 32'h104};
        check("stall_capture", 128'(mvec()), 128'(held));
        ex_if.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex_if.RD1E      = 32'(i * 17 + 100);
            ex_if.RD2E      = 32'(i + 40);
            ex_if.RdE       = 5'(i + 20);
            ex_if.MemWriteE = 1'b1;
            ex_if.RegWriteE = 1'b0;
            ex_if.PCPlus4E  = 32'(i * 4);
            step();
            check("stall_hold", 128'(mvec()), 128'(held));
        end

        // Held MEM result still feeds forwarding: 12 - 12 == 0 branches
        ex_if.ForwardAE   = 2'b10;
        ex_if.ALUSrcE     = 1'b1;
        ex_if.ImmExtE     = 32'd12;
        ex_if.ALUControlE = 3'b001;
        ex_if.BranchE     = 1'b1;
        #1;
        check("stall_fwd_branch", 128'(ex_if.PCSrcE), 128'(1));

        // Flush beats stall
        ex_if.flush = 1'b1;
        step();
        check("flush_over_stall", 128'(mvec()), 128'(0));

        // Flush beats enable
        clear_inputs();
        ex_if.RD1E = 32'd5; ex_if.RD2E = 32'd7; ex_if.RegWriteE = 1'b1; ex_if.RdE = 5'd3;
        step();
        check("pre_flush_cap", 128'(ex_if.ALUResultM), 128'(32'd12));
        ex_if.flush = 1'b1;
        step();
        check("flush_over_enable", 128'(mvec()), 128'(0));
        ex_if.flush = 1'b0;

        // Mid-stream reset, then first capture after release with enable
        step();
        check("resume_cap", 128'({ex_if.RegWriteM, ex_if.ALUResultM}), 128'({1'b1, 32'd12}));
        reset = 1'b1;
        step();
        check("mid_reset", 128'(mvec()), 128'(0));
        reset = 1'b0;
        ex_if.enable = 1'b0;
        step();
        check("post_reset_stall", 128'(mvec()), 128'(0));
        ex_if.enable = 1'b1;
        step();
        check("first_capture", 128'({ex_if.RegWriteM, ex_if.ALUResultM, ex_if.RdM}),
              128'({1'b1, 32'd12, 5'd3}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
